// File: rtl/param_seq_alu_if.sv
// param_seq_alu_if: operand/result handshake bus between sequencer (master) and ALU (slave)
interface param_seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_CONT;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_OUT;
  logic             Zero, Pos, Neg, Carry, Ovf;
  logic             GT, LT, EQ, GTS, LTS;
  modport master (
    output in_valid, A, B, ALU_CONT, out_ready,
    input  in_ready, out_valid, ALU_OUT, Zero, Pos, Neg, Carry, Ovf, GT, LT, EQ, GTS, LTS
  );
  modport slave (
    input  in_valid, A, B, ALU_CONT, out_ready,
    output in_ready, out_valid, ALU_OUT, Zero, Pos, Neg, Carry, Ovf, GT, LT, EQ, GTS, LTS
  );
endinterface

// File: rtl/param_seq_alu.sv
// param_seq_alu: registered WIDTH-bit 16-op ALU with valid/ready handshakes and multi-cycle shifts; PARAM_SEQ_ALU_SAT_EN makes opcodes 0-3 saturate
module param_seq_alu #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic            clk,
  input logic            rst_n,
  input logic            en,
  param_seq_alu_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] w_q, res_q;
  logic [4:0]       flg_q, cmp_q;
  logic [SHW-1:0]   n;
  logic             accept, go_busy, fin;
  logic [WIDTH-1:0] op2, arith_res, one_res, step_res, fin_res;
  logic [WIDTH:0]   arith;
  logic             arith_ovf, one_c, one_o, step_c, fin_c, fin_o;
  assign n         = bus.B[SHW-1:0];
  assign bus.in_ready = rst_n && en && state_q == IDLE;
  assign accept    = bus.in_valid && bus.in_ready;
  assign go_busy   = bus.ALU_CONT[3:2] == 2'b01 && n != '0;
  assign fin       = accept ? !go_busy : state_q == BUSY && cnt_q == SHW'(1);
  assign op2       = bus.ALU_CONT[1] ? WIDTH'(1) : bus.B;
  assign arith     = bus.ALU_CONT[0] ? {1'b0, bus.A} - {1'b0, op2} : {1'b0, bus.A} + {1'b0, op2};
  assign arith_ovf = (arith[WIDTH-1] != bus.A[WIDTH-1]) && ((bus.A[WIDTH-1] != op2[WIDTH-1]) == bus.ALU_CONT[0]);
`ifdef PARAM_SEQ_ALU_SAT_EN
  assign arith_res = arith[WIDTH] ? (bus.ALU_CONT[0] ? '0 : '1) : arith[WIDTH-1:0];
`else
  assign arith_res = arith[WIDTH-1:0];
`endif
  // Single-cycle result; shifts only land here with n=0, which passes A through
  always_comb begin
    one_res = bus.A;
    one_c   = 1'b0;
    one_o   = 1'b0;
    case (bus.ALU_CONT)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        one_res = arith_res;
        one_c   = arith[WIDTH];
        one_o   = arith_ovf;
      end
      4'h8:    one_res = ~bus.A;
      4'h9:    one_res = ~bus.B;
      4'hA:    one_res = bus.A & bus.B;
      4'hB:    one_res = bus.A | bus.B;
      4'hC:    one_res = ~(bus.A & bus.B);
      4'hD:    one_res = ~(bus.A | bus.B);
      4'hE:    one_res = bus.A ^ bus.B;
      4'hF:    one_res = ~(bus.A ^ bus.B);
      default: one_res = bus.A;
    endcase
  end
  assign step_res = op_q[1] ? (op_q[0] ? {w_q[0], w_q[WIDTH-1:1]} : {w_q[WIDTH-2:0], w_q[WIDTH-1]})
                            : (op_q[0] ? {1'b0, w_q[WIDTH-1:1]} : {w_q[WIDTH-2:0], 1'b0});
  assign step_c   = !op_q[1] && (op_q[0] ? w_q[0] : w_q[WIDTH-1]);
  assign fin_res  = state_q == BUSY ? step_res : one_res;
  assign fin_c    = state_q == BUSY ? step_c : one_c;
  assign fin_o    = state_q != BUSY && one_o;
  // Next state: accept in IDLE, count down in BUSY, release on out_ready in DONE
  always_comb begin
    state_d = state_q == IDLE ? (accept ? (go_busy ? BUSY : DONE) : IDLE)
            : state_q == BUSY ? (cnt_q == SHW'(1) ? DONE : BUSY)
            : bus.out_ready ? IDLE : DONE;
  end
  // State, operand latch, one-bit-per-cycle shift engine and result/flag registers, all frozen when en is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      w_q     <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      cmp_q   <= '0;
    end else if (en) begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= bus.ALU_CONT[1:0];
        w_q   <= bus.A;
        cnt_q <= n;
        cmp_q <= {bus.A > bus.B, bus.A < bus.B, bus.A == bus.B,
                  $signed(bus.A) > $signed(bus.B), $signed(bus.A) < $signed(bus.B)};
      end
      if (state_q == BUSY) begin
        w_q   <= step_res;
        cnt_q <= cnt_q - SHW'(1);
      end
      if (fin) begin
        res_q <= fin_res;
        flg_q <= {fin_res == '0, !fin_res[WIDTH-1] && fin_res != '0, fin_res[WIDTH-1], fin_c, fin_o};
      end
    end
  end
  assign bus.out_valid = state_q == DONE;
  assign bus.ALU_OUT   = res_q;
  assign {bus.Zero, bus.Pos, bus.Neg, bus.Carry, bus.Ovf} = flg_q;
  assign {bus.GT, bus.LT, bus.EQ, bus.GTS, bus.LTS}       = cmp_q;
endmodule

// File: tb/tb_param_seq_alu.sv
// tb_param_seq_alu: directed checks of param_seq_alu (WIDTH=8) handshake, arithmetic, shifts, backpressure and en gating
module tb_param_seq_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  param_seq_alu_if #(.WIDTH(8)) bus ();
  param_seq_alu #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .en(en), .bus(bus));
  logic [9:0] flg;
  assign flg = {bus.Zero, bus.Pos, bus.Neg, bus.Carry, bus.Ovf, bus.GT, bus.LT, bus.EQ, bus.GTS, bus.LTS};
`ifdef PARAM_SEQ_ALU_SAT_EN
  localparam logic [7:0] ADD_RES = 8'hFF;
  localparam logic [9:0] ADD_FLG = 10'b0011010001;
  localparam logic [7:0] DEC0    = 8'h00;
`else
  localparam logic [7:0] ADD_RES = 8'h00;
  localparam logic [9:0] ADD_FLG = 10'b1001010001;
  localparam logic [7:0] DEC0    = 8'hFF;
`endif
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] r;
    logic       c;
    logic       o;
  } vec_t;
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    int w = 0;
    bus.A = a;
    bus.B = b;
    bus.ALU_CONT = op;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && w < 20) begin
      tick();
      w++;
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_ready: in_ready=%b required 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    tick(2);
    total++;
    if ({bus.out_valid, bus.in_ready, bus.ALU_OUT, flg} !== 20'h0) begin
      bad++;
      $display("FAIL reset_init: ov=%b ir=%b out=%h flg=%b required all 0", bus.out_valid, bus.in_ready, bus.ALU_OUT, flg);
    end
    rst_n = 1'b1;
    issue(8'h01, 8'h05, 4'h4);
    tick(2);
    rst_n = 1'b0;
    tick();
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
      bad++;
      $display("FAIL reset_hold: ov=%b ir=%b required 0 0", bus.out_valid, bus.in_ready);
    end
    tick();
    rst_n = 1'b1;
    #1;
    total++;
    if ({bus.out_valid, bus.in_ready, bus.ALU_OUT, flg} !== {2'b01, 8'h00, 10'h0}) begin
      bad++;
      $display("FAIL reset_mid_busy: ov=%b ir=%b out=%h flg=%b required ov=0 ir=1 out=00 flg=0", bus.out_valid, bus.in_ready, bus.ALU_OUT, flg);
    end
    tick(7);
    total++;
    if ({bus.out_valid, bus.ALU_OUT} !== 9'h000) begin
      bad++;
      $display("FAIL reset_discard: ov=%b out=%h required 0 00", bus.out_valid, bus.ALU_OUT);
    end
  endtask
  task automatic test_add();
    bus.out_ready = 1'b1;
    issue(8'hFF, 8'h01, 4'h0);
    total++;
    if ({bus.out_valid, bus.ALU_OUT, flg} !== {1'b1, ADD_RES, ADD_FLG}) begin
      bad++;
      $display("FAIL add_carry: ov=%b out=%h flg=%b required 1 %h %b", bus.out_valid, bus.ALU_OUT, flg, ADD_RES, ADD_FLG);
    end
    tick();
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL add_release: ov=%b ir=%b required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask
  task automatic test_ovf();
    bus.out_ready = 1'b1;
    issue(8'h7F, 8'h01, 4'h0);
    total++;
    if ({bus.out_valid, bus.ALU_OUT, flg} !== {1'b1, 8'h80, 10'b0010110010}) begin
      bad++;
      $display("FAIL add_ovf: ov=%b out=%h flg=%b required 1 80 0010110010", bus.out_valid, bus.ALU_OUT, flg);
    end
    tick();
  endtask
  task automatic test_ops();
    vec_t tv[9];
    tv = '{'{8'h10, 8'h03, 4'h1, 8'h0D, 1'b0, 1'b0},
           '{8'h80, 8'h00, 4'h3, 8'h7F, 1'b0, 1'b1},
           '{8'h00, 8'h00, 4'h3, DEC0,  1'b1, 1'b0},
           '{8'h7F, 8'h00, 4'h2, 8'h80, 1'b0, 1'b1},
           '{8'hF0, 8'h3C, 4'hA, 8'h30, 1'b0, 1'b0},
           '{8'hF0, 8'h3C, 4'hF, 8'h33, 1'b0, 1'b0},
           '{8'hF0, 8'h3C, 4'h9, 8'hC3, 1'b0, 1'b0},
           '{8'hF0, 8'h3C, 4'hD, 8'h03, 1'b0, 1'b0},
           '{8'h85, 8'h00, 4'h4, 8'h85, 1'b0, 1'b0}};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      issue(tv[i].a, tv[i].b, tv[i].op);
      total++;
      if ({bus.out_valid, bus.ALU_OUT, bus.Carry, bus.Ovf} !== {1'b1, tv[i].r, tv[i].c, tv[i].o}) begin
        bad++;
        $display("FAIL op_vec%0d: ov=%b out=%h c=%b o=%b required 1 %h %b %b", i, bus.out_valid, bus.ALU_OUT, bus.Carry, bus.Ovf, tv[i].r, tv[i].c, tv[i].o);
      end
      tick();
    end
  endtask
  task automatic test_rotate();
    int lat = 1;
    bus.out_ready = 1'b0;
    issue(8'h81, 8'h03, 4'h6);
    while (!bus.out_valid && lat < 20) begin
      total++;
      if (bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL rol_busy_ready: in_ready=%b required 0", bus.in_ready);
      end
      tick();
      lat++;
    end
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL rol_latency: got %0d cycles required 4", lat);
    end
    total++;
    if ({bus.ALU_OUT, flg} !== {8'h0C, 10'b0100010001}) begin
      bad++;
      $display("FAIL rol_result: out=%h flg=%b required 0c 0100010001", bus.ALU_OUT, flg);
    end
    tick();
    total++;
    if ({bus.out_valid, bus.in_ready, bus.ALU_OUT} !== {2'b10, 8'h0C}) begin
      bad++;
      $display("FAIL rol_done_hold: ov=%b ir=%b out=%h required 1 0 0c", bus.out_valid, bus.in_ready, bus.ALU_OUT);
    end
    bus.out_ready = 1'b1;
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rol_release: ov=%b required 0", bus.out_valid);
    end
  endtask
  task automatic test_backpressure();
    int lat = 1;
    bus.out_ready = 1'b0;
    issue(8'h03, 8'h01, 4'h5);
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    total++;
    if ({lat[7:0], flg} !== {8'd2, 10'b0101010010}) begin
      bad++;
      $display("FAIL shr_done: lat=%0d flg=%b required 2 0101010010", lat, flg);
    end
    bus.A = 8'h22;
    bus.B = 8'h11;
    bus.ALU_CONT = 4'h0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({bus.out_valid, bus.in_ready, bus.ALU_OUT, bus.Carry} !== {2'b10, 8'h01, 1'b1}) begin
        bad++;
        $display("FAIL bp_hold%0d: ov=%b ir=%b out=%h c=%b required 1 0 01 1", i, bus.out_valid, bus.in_ready, bus.ALU_OUT, bus.Carry);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp_release: ov=%b ir=%b required 0 1", bus.out_valid, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    total++;
    if ({bus.out_valid, bus.ALU_OUT} !== {1'b1, 8'h33}) begin
      bad++;
      $display("FAIL bp_next_op: ov=%b out=%h required 1 33", bus.out_valid, bus.ALU_OUT);
    end
    tick();
  endtask
  task automatic test_en_gating();
    int lat = 1;
    bus.out_ready = 1'b1;
    issue(8'h01, 8'h04, 4'h4);
    tick();
    lat++;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      lat++;
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL en_freeze%0d: ov=%b required 0", i, bus.out_valid);
      end
    end
    en = 1'b1;
    while (!bus.out_valid && lat < 30) begin
      tick();
      lat++;
    end
    total++;
    if ({lat[7:0], bus.ALU_OUT, bus.Carry} !== {8'd8, 8'h10, 1'b0}) begin
      bad++;
      $display("FAIL en_shl: lat=%0d out=%h c=%b required 8 10 0", lat, bus.ALU_OUT, bus.Carry);
    end
    en = 1'b0;
    tick(2);
    total++;
    if ({bus.out_valid, bus.in_ready, bus.ALU_OUT} !== {2'b10, 8'h10}) begin
      bad++;
      $display("FAIL en_done_hold: ov=%b ir=%b out=%h required 1 0 10", bus.out_valid, bus.in_ready, bus.ALU_OUT);
    end
    en = 1'b1;
    tick();
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL en_release: ov=%b ir=%b required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.A = '0;
    bus.B = '0;
    bus.ALU_CONT = '0;
    test_reset();
    test_add();
    test_ovf();
    test_ops();
    test_rotate();
    test_backpressure();
    test_en_gating();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/param_seq_alu.md
Name: param_seq_alu

Overview:
- Parametrised, registered successor to the team's 4-bit 16-operation ALU.
- Same 4-bit opcode map, but the operand width is set by WIDTH.
- Adds valid/ready handshakes, registered status flags (plus carry and signed overflow), and multi-cycle shift/rotate by a variable amount.
- Sits between a sequencer/register file and writeback; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥4 and a power of 2.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- en  input  1  global enable; when low, the FSM and all registers hold and in_ready=0
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  block can accept an operation
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B; B[SHW-1:0] is the shift amount for opcodes 4-7
- ALU_CONT  input  4  opcode
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts the result
- ALU_OUT  output  WIDTH  registered result
- Zero, Pos, Neg, Carry, Ovf  output  1 each  result flags
- GT, LT, EQ, GTS, LTS  output  1 each  unsigned/signed compares of the accepted A, B

Behaviour:
- Reset: on clk rising edge with rst_n=0 (synchronous, active-low):
  - state=IDLE.
  - ALU_OUT=0; all flags 0; out_valid=0; in_ready=0 during reset.
  - Any in-flight operation is discarded; there is no partial output.
- Opcodes (arithmetic mod 2^WIDTH):
  - 0 A+B; 1 A-B; 2 A+1; 3 A-1.
  - 4 SHL A by n; 5 logical SHR A by n; 6 ROL A by n; 7 ROR A by n, where n=B[SHW-1:0].
  - 8 ~A; 9 ~B; A A&B; B A|B; C ~(A&B); D ~(A|B); E A^B; F ~(A^B).
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=en. Accept when in_valid&&in_ready at the edge; A, B, opcode and the compare flags are latched.
  - Single-cycle ops (all except 4-7), and shifts with n=0: result and flags registered at the accept edge → DONE. out_valid is high the next cycle, i.e. latency 1.
  - Shifts with n>0: → BUSY with counter=n. Each en-high cycle shifts/rotates the working register by one bit and decrements the counter. When the counter reaches 0 → DONE. out_valid rises n+1 cycles after accept.
  - DONE: out_valid=1. ALU_OUT and all flags are held stable until out_valid&&out_ready at an edge, then → IDLE. in_ready is never high in DONE or BUSY.
  - Maximum throughput: one operation per 2 cycles (single-cycle ops with out_ready held high).
- Flags, registered with the result and held with it:
  - Zero = (result==0).
  - Neg = result[WIDTH-1].
  - Pos = !Neg && !Zero.
  - Carry:
    - add/inc: carry-out.
    - sub/dec: borrow, i.e. A<B for sub and A==0 for dec.
    - SHL/SHR: last bit shifted out (0 if n=0).
    - ROL/ROR and logic ops: 0.
  - Ovf: signed overflow for opcodes 0-3; 0 otherwise.
  - GT/LT/EQ: unsigned compare of the latched A, B. GTS/LTS: signed compare ($signed). Computed for every opcode.
- en=0 in any state freezes state, counter and outputs; out_valid stays as it was, but no handshake completes.
- out_ready is ignored outside DONE; in_valid is ignored outside IDLE.

Optional Feature:
- Macro: PARAM_SEQ_ALU_SAT_EN.
- Defined: opcodes 0-3 saturate unsigned.
  - Add/inc overflowing 2^WIDTH-1 → all-ones.
  - Sub/dec borrow → 0.
  - Carry and Ovf still report the unsaturated condition.
  - Zero/Pos/Neg reflect the saturated result.
- Undefined: opcodes 0-3 wrap modulo 2^WIDTH. No saturation logic is present.

Test Plan (WIDTH=8):
- Reset: rst_n=0 for 2 cycles mid-BUSY (SHL, n=5) → next cycle out_valid=0, ALU_OUT=0x00, all flags 0, state IDLE, in_ready=1 once rst_n=1.
- Add: A=0xFF, B=0x01, op=0, out_ready=1 → one cycle later out_valid=1, ALU_OUT=0x00, Zero=1, Carry=1, Ovf=0, GT=1, LTS=1. With PARAM_SEQ_ALU_SAT_EN: ALU_OUT=0xFF, Neg=1, Carry=1.
- Signed overflow: A=0x7F, B=0x01, op=0 → ALU_OUT=0x80, Neg=1, Ovf=1, Carry=0, GTS=1.
- Multi-cycle rotate: A=0x81, B=0x03, op=6 → out_valid exactly 4 cycles after accept, ALU_OUT=0x0C, Carry=0, in_ready=0 throughout BUSY/DONE.
- Backpressure: SHR A=0x03, B=0x01, out_ready=0 for 5 cycles → ALU_OUT=0x01, Carry=1 held stable. A new in_valid is not accepted until one cycle after out_ready=1.
- en gating: deassert en for 3 cycles during SHL n=4 (A=0x01) → completion delayed by exactly 3 cycles, ALU_OUT=0x10.
